// File: rtl/arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank_if.sv
// Signal bundle for the sync/filter bank. All signals are level-type; there is
// no valid/ready handshake. The master drives the async inputs and filt_en.
interface arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d_async;
    logic             filt_en;
    logic [WIDTH-1:0] o_sync;
    logic [WIDTH-1:0] o_filt;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             chg_any;

    modport master (
        output d_async,
        output filt_en,
        input  o_sync,
        input  o_filt,
        input  rise_pulse,
        input  fall_pulse,
        input  chg_any
    );

    modport slave (
        input  d_async,
        input  filt_en,
        output o_sync,
        output o_filt,
        output rise_pulse,
        output fall_pulse,
        output chg_any
    );
endinterface

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank.sv
// Multi-channel synchronizer bank: STAGES-deep sync chain per bit, a per-channel
// stability filter with runtime bypass, and registered rise/fall pulses.
module arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank #(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input logic clk,
    input logic rstb,
    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank_if.slave bus
);

    localparam int CNT_W = ($clog2(FILT_CNT + 1) > 1) ? $clog2(FILT_CNT + 1) : 1;
    localparam bit FILT_ON = (FILT_CNT > 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILT_CNT > 1) ? FILT_CNT - 1 : 0);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("WIDTH must be in 1..64");
        end
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("STAGES must be in 2..4");
        end
        if (FILT_CNT < 0 || FILT_CNT > 255) begin : g_bad_filt
            $error("FILT_CNT must be in 0..255");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Plain flop chain; only the last stage is ever observed downstream.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= bus.d_async;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[STAGES-1];

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!bus.filt_en || !FILT_ON) begin
                filt_d[i] = sync_out[i];
                cnt_d[i]  = '0;
            end else if (sync_out[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync_out[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Pulses are computed from the next filtered value so they line up with
    // the first cycle o_filt shows the new level.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            filt_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            rise_q <= filt_d & ~filt_q;
            fall_q <= ~filt_d & filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.o_sync     = sync_out;
    assign bus.o_filt     = filt_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.chg_any    = |(rise_q | fall_q);

    a_no_double_pulse: assert property (@(posedge clk) disable iff (!rstb)
        (rise_q & fall_q) == '0);

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cnt_bound
            a_cnt_bound: assert property (@(posedge clk) disable iff (!rstb)
                cnt_q[g] <= CNT_LAST);
        end
    endgenerate

endmodule

// File: tb/tb_arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank.sv
// Bench for the sync/filter bank: three configurations, pulse scoreboard on the
// main instance plus directed cycle-by-cycle checks.
module tb_arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rstb0, rstb1, rstb2;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank_if #(.WIDTH(W)) bus0 ();
    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank_if #(.WIDTH(W)) bus1 ();
    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank_if #(.WIDTH(W)) bus2 ();

    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank #(
        .WIDTH(W), .STAGES(2), .FILT_CNT(3), .RST_VAL(8'h00)
    ) dut0 (.clk(clk), .rstb(rstb0), .bus(bus0));

    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank #(
        .WIDTH(W), .STAGES(2), .FILT_CNT(3), .RST_VAL(8'hA5)
    ) dut1 (.clk(clk), .rstb(rstb1), .bus(bus1));

    arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank #(
        .WIDTH(W), .STAGES(4), .FILT_CNT(0), .RST_VAL(8'h00)
    ) dut2 (.clk(clk), .rstb(rstb2), .bus(bus2));

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] r, input logic [W-1:0] f, input int cyc);
        exp_t e;
        e.rise = r;
        e.fall = f;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // Drive a new settled value on dut0 and queue the pulses it must cause.
    task automatic step0(input logic [W-1:0] nd, input int lat, input int hold);
        logic [W-1:0] od;
        od = bus0.d_async;
        if (nd != od) push_exp(nd & ~od, ~nd & od, edge_cnt + lat);
        bus0.d_async = nd;
        repeat (hold) @(negedge clk);
    endtask

    // Monitor: every pulse seen on dut0 must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: no pulse observed, expected rise %h fall %h at edge %0d",
                         exp_q[0].rise, exp_q[0].fall, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus0.chg_any || (|bus0.rise_pulse) || (|bus0.fall_pulse)) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != edge_cnt) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got rise %h fall %h chg %b at edge %0d, expected none",
                             bus0.rise_pulse, bus0.fall_pulse, bus0.chg_any, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("rise_pulse", bus0.rise_pulse, e.rise);
                    check("fall_pulse", bus0.fall_pulse, e.fall);
                    check("chg_any", W'(bus0.chg_any), W'(1));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        rstb0 = 1'b0;
        rstb1 = 1'b0;
        rstb2 = 1'b0;
        bus0.d_async = '0;
        bus0.filt_en = 1'b1;
        bus1.d_async = W'($urandom);
        bus1.filt_en = 1'b1;
        bus2.d_async = '0;
        bus2.filt_en = 1'b1;

        @(negedge clk);
        check("rst0_o_sync", bus0.o_sync, 8'h00);
        check("rst0_o_filt", bus0.o_filt, 8'h00);
        check("rst0_chg", W'(bus0.chg_any), W'(0));
        repeat (2) @(negedge clk);
        rstb0 = 1'b1;
        rstb2 = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Latency on channel 0
        e = edge_cnt;
        push_exp(8'h01, 8'h00, e + 5);
        bus0.d_async = 8'h01;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("lat_o_sync0", W'(bus0.o_sync[0]), W'(c >= 2));
            check("lat_o_filt0", W'(bus0.o_filt[0]), W'(c >= 5));
        end
        step0(8'h00, 5, 8);

        // Glitch of two cycles on channel 3 must be rejected
        bus0.d_async = 8'h08;
        repeat (2) @(negedge clk);
        bus0.d_async = 8'h00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("glitch_o_filt3", W'(bus0.o_filt[3]), W'(0));
        end
        // Three-cycle high is long enough to pass
        push_exp(8'h08, 8'h00, edge_cnt + 5);
        bus0.d_async = 8'h08;
        repeat (3) @(negedge clk);
        push_exp(8'h00, 8'h08, edge_cnt + 5);
        bus0.d_async = 8'h00;
        repeat (2) @(negedge clk);
        check("pass_o_filt3_hi", W'(bus0.o_filt[3]), W'(1));
        repeat (6) @(negedge clk);
        check("pass_o_filt3_lo", W'(bus0.o_filt[3]), W'(0));

        // Bypass: o_filt follows o_sync one edge later
        bus0.filt_en = 1'b0;
        for (int t = 0; t < 2; t++) begin
            logic nv;
            nv = (t == 0);
            e = edge_cnt;
            push_exp(nv ? 8'h02 : 8'h00, nv ? 8'h00 : 8'h02, e + 3);
            bus0.d_async = nv ? 8'h02 : 8'h00;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                check("byp_o_sync1", W'(bus0.o_sync[1]), W'((c >= 2) ? nv : !nv));
                check("byp_o_filt1", W'(bus0.o_filt[1]), W'((c >= 3) ? nv : !nv));
            end
        end
        bus0.filt_en = 1'b1;
        repeat (2) @(negedge clk);

        // Drop filt_en while channel 1 counter is at 1
        e = edge_cnt;
        bus0.d_async = 8'h02;
        repeat (3) @(negedge clk);
        check("mid_o_filt1_pre", W'(bus0.o_filt[1]), W'(0));
        bus0.filt_en = 1'b0;
        push_exp(8'h02, 8'h00, e + 4);
        @(negedge clk);
        check("mid_o_filt1_post", W'(bus0.o_filt[1]), W'(1));
        bus0.filt_en = 1'b1;
        repeat (2) @(negedge clk);
        step0(8'h00, 5, 8);

        // Simultaneous multi-channel changes
        step0(8'h0F, 5, 8);
        check("multi_o_filt_0f", bus0.o_filt, 8'h0F);
        step0(8'hF0, 5, 8);
        check("multi_o_filt_f0", bus0.o_filt, 8'hF0);
        step0(8'h00, 5, 8);

        // Async reset while channel 2 counter is at 2
        bus0.d_async = 8'h04;
        repeat (4) @(negedge clk);
        #2;
        rstb0 = 1'b0;
        #1;
        check("arst_o_sync", bus0.o_sync, 8'h00);
        check("arst_o_filt", bus0.o_filt, 8'h00);
        check("arst_rise", bus0.rise_pulse, 8'h00);
        check("arst_chg", W'(bus0.chg_any), W'(0));
        bus0.d_async = 8'h00;
        repeat (2) @(negedge clk);
        rstb0 = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_after_o_filt", bus0.o_filt, 8'h00);

        // Non-zero reset value on dut1
        for (int c = 0; c < 4; c++) begin
            bus1.d_async = W'($urandom);
            @(negedge clk);
            check("rv_in_rst_o_sync", bus1.o_sync, 8'hA5);
            check("rv_in_rst_o_filt", bus1.o_filt, 8'hA5);
        end
        bus1.d_async = 8'hA5;
        rstb1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("rv_o_sync", bus1.o_sync, 8'hA5);
            check("rv_o_filt", bus1.o_filt, 8'hA5);
            check("rv_pulses", bus1.rise_pulse | bus1.fall_pulse, 8'h00);
            check("rv_chg", W'(bus1.chg_any), W'(0));
        end

        // STAGES=4, FILT_CNT=0: five-edge latency
        e = edge_cnt;
        bus2.d_async = 8'h01;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check("s4_o_sync0", W'(bus2.o_sync[0]), W'(c >= 4));
            check("s4_o_filt0", W'(bus2.o_filt[0]), W'(c >= 5));
            check("s4_rise0", W'(bus2.rise_pulse[0]), W'(c == 5));
            check("s4_chg", W'(bus2.chg_any), W'(c == 5));
        end

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: no pulse observed, expected rise %h fall %h at edge %0d",
                     exp_q[0].rise, exp_q[0].fall, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank.md
Name: arf086b128e1r1w0cbbehsaa4acw_sync_filter_bank

Overview:
Parametrised multi-channel synchronizer bank for asynchronous control inputs into the register-file array clock domain. It supersedes the fixed single-bit, two-flop doublesync wrappers. It adds:
- configurable synchronizer depth;
- a per-channel stability (glitch) filter with a runtime bypass;
- registered rise and fall pulse outputs.
It sits between the array's external async control pins and the array control logic.

Parameters:
WIDTH, 8, number of independent channels (1..64).
STAGES, 2, synchronizer flop depth per channel (2..4); any other value is an elaboration error.
FILT_CNT, 3, consecutive stable cycles required before the filtered output updates (0..255); 0 or 1 means no filtering; above 255 is an elaboration error.
RST_VAL, '0, WIDTH-bit reset value for the synchronizer stages and the filtered output.

Ports:
clk  input  1  single clock; all flops are rising-edge.
rstb  input  1  asynchronous, active-low reset; assertion is async, deassertion is assumed synchronized upstream.
d_async  input  WIDTH  asynchronous channel inputs.
filt_en  input  1  synchronous; 1 enables the filter, 0 bypasses it; quasi-static but may toggle at any time.
o_sync  output  WIDTH  raw synchronized value (last synchronizer stage).
o_filt  output  WIDTH  filtered, stable value.
rise_pulse  output  WIDTH  one-cycle pulse when o_filt[i] goes 0->1.
fall_pulse  output  WIDTH  one-cycle pulse when o_filt[i] goes 1->0.
chg_any  output  1  OR-reduce of (rise_pulse | fall_pulse); combinational from registers only.

Behaviour:
- Reset (rstb=0, async):
  - all synchronizer stages = RST_VAL, so o_sync = RST_VAL;
  - o_filt = RST_VAL;
  - per-channel counters cnt[i] = 0;
  - rise_pulse = fall_pulse = 0, chg_any = 0.
- After reset release, no pulse is generated merely because d_async differs from RST_VAL until o_filt actually changes.
- Synchronizer: per bit, a chain of STAGES flops; o_sync is the last stage.
  - d_async stable before edge k appears on o_sync after edge k+STAGES-1.
- Filter, per channel, with counter width CNT_W = max(1, clog2(FILT_CNT+1)):
  - Bypass (filt_en=0 or FILT_CNT<=1): o_filt[i] <= o_sync[i] every edge; cnt[i] <= 0.
  - Filtering, o_sync[i] == o_filt[i]: cnt[i] <= 0; o_filt[i] holds.
  - Filtering, o_sync[i] != o_filt[i] and cnt[i] == FILT_CNT-1: o_filt[i] <= o_sync[i]; cnt[i] <= 0.
  - Filtering, o_sync[i] != o_filt[i] otherwise: cnt[i] <= cnt[i]+1.
  - Result: o_filt changes FILT_CNT edges after o_sync changes, provided o_sync holds.
  - Total latency from d_async to o_filt = STAGES+FILT_CNT edges (bypass: STAGES+1).
- Glitch rejection: if o_sync[i] returns to o_filt[i] before the count completes, cnt clears; no o_filt change and no pulse.
- filt_en 1->0 mid-count: cnt clears; o_filt follows o_sync on the next edge (the bypass rule).
- filt_en 0->1: counting starts from 0 on the following edges.
- Pulses (registered in the same edge as o_filt):
  - rise_pulse[i] <= next_o_filt[i] & ~o_filt[i];
  - fall_pulse[i] <= ~next_o_filt[i] & o_filt[i];
  - so a pulse is high exactly in the first cycle o_filt shows the new value, for one cycle only;
  - rise_pulse[i] and fall_pulse[i] are never high together.
- Channels are fully independent; simultaneous changes on multiple channels produce simultaneous pulses.
- No counter wrap is possible: the counter never exceeds FILT_CNT-1.

Test Plan:
- Reset value:
  - Stimulus: RST_VAL=8'hA5, hold rstb=0 with random d_async, then release with d_async=8'hA5.
  - Required: o_sync=o_filt=8'hA5, all pulses 0, chg_any=0 for 20 cycles.
- Latency:
  - Stimulus: STAGES=2, FILT_CNT=3, filt_en=1; d_async[0] 0->1 before edge 1.
  - Required: o_sync[0]=1 after edge 2; o_filt[0]=1 after edge 5; rise_pulse[0]=1 only in the cycle after edge 5; chg_any matches.
- Glitch rejection:
  - Stimulus: same config; o_sync[3] high for 2 cycles then low.
  - Required: o_filt[3] stays 0, no pulse; a 3-cycle high does update o_filt[3] and produces one rise pulse.
- Bypass and mid-count toggle:
  - Stimulus: filt_en=0 with a d_async[1] toggle.
  - Required: o_filt[1] follows o_sync[1] one edge later.
  - Stimulus: drop filt_en at cnt=1.
  - Required: o_filt updates on the next edge with a single pulse.
- Multi-channel and fall:
  - Stimulus: d_async 8'h0F -> 8'hF0 in one cycle.
  - Required: after latency, rise_pulse=8'hF0 and fall_pulse=8'h0F in the same cycle, chg_any=1 for exactly one cycle.
- Async reset mid-count:
  - Stimulus: assert rstb=0 between clock edges while cnt=2.
  - Required: immediate return to reset values; no pulse after release.
  - Repeat with STAGES=4, FILT_CNT=0.
  - Required: latency of 5 edges.
